// File: rtl/change_dispenser.sv
// Greedy coin change dispenser with a req/ack hopper handshake and fixed inter-coin gap.
// Optional feature: define DOLLAR_COIN_EN to include dollar coins in the greedy selection.
module change_dispenser #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] price,
  input  logic [10:0] paid,
  input  logic        coin_ack,
  output logic        coin_req,
  output logic [1:0]  coin_sel,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [10:0] change_left,
  output logic [6:0]  coin_count
);

  localparam int unsigned AMT_W = 11;
  localparam int unsigned CNT_W = 7;
  localparam int unsigned GAP_W = 8;

`ifdef DOLLAR_COIN_EN
  localparam logic DOLLAR_EN = 1'b1;
`else
  localparam logic DOLLAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_GAP, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_coin_req, w_coin_req_nxt;
  logic [1:0]         r_coin_sel, w_coin_sel_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;
  logic [AMT_W-1:0]   r_change_left, w_change_left_nxt;
  logic [CNT_W-1:0]   r_coin_count, w_coin_count_nxt;
  logic               r_underpaid, w_underpaid_nxt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
  logic               w_gap_last;

  function automatic logic [AMT_W-1:0] f_coin_val(input logic [1:0] sel);
    case (sel)
      2'b00:   f_coin_val = AMT_W'(5);
      2'b01:   f_coin_val = AMT_W'(10);
      2'b10:   f_coin_val = AMT_W'(25);
      default: f_coin_val = AMT_W'(100);
    endcase
  endfunction

  // Largest enabled coin not exceeding amt; amt is always a nonzero multiple of 5 here.
  function automatic logic [1:0] f_pick(input logic [AMT_W-1:0] amt);
    logic [1:0] sel;
    sel = 2'b00;
    if (amt >= AMT_W'(10)) sel = 2'b01;
    if (amt >= AMT_W'(25)) sel = 2'b10;
    if (DOLLAR_EN && (amt >= AMT_W'(100))) sel = 2'b11;
    return sel;
  endfunction

  assign w_gap_last = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));

  always_comb begin
    w_state_nxt       = r_state;
    w_coin_req_nxt    = r_coin_req;
    w_coin_sel_nxt    = r_coin_sel;
    w_done_nxt        = 1'b0;
    w_err_nxt         = 1'b0;
    w_change_left_nxt = r_change_left;
    w_coin_count_nxt  = r_coin_count;
    w_underpaid_nxt   = r_underpaid;
    w_gap_cnt_nxt     = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_underpaid_nxt   = (paid < price);
          w_change_left_nxt = (paid < price) ? '0 : AMT_W'(paid - price);
          w_coin_count_nxt  = '0;
          w_state_nxt       = S_CHECK;
        end
      end
      S_CHECK: begin
        if (r_underpaid || ((r_change_left % AMT_W'(5)) != '0)) begin
          w_err_nxt         = 1'b1;
          w_change_left_nxt = '0;
          w_state_nxt       = S_IDLE;
        end else if (r_change_left == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_coin_sel_nxt = f_pick(r_change_left);
          w_state_nxt    = S_REQ;
        end
      end
      S_REQ: begin
        // coin_ack only counts once the request is actually visible on coin_req
        if (r_coin_req && coin_ack) begin
          w_change_left_nxt = r_change_left - f_coin_val(r_coin_sel);
          w_coin_count_nxt  = CNT_W'(r_coin_count + CNT_W'(1));
          w_coin_req_nxt    = 1'b0;
          w_gap_cnt_nxt     = '0;
          w_state_nxt       = S_GAP;
        end else begin
          w_coin_req_nxt = 1'b1;
        end
      end
      S_GAP: begin
        if (w_gap_last) begin
          if (r_change_left == '0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_coin_sel_nxt = f_pick(r_change_left);
            w_coin_req_nxt = 1'b1;
            w_state_nxt    = S_REQ;
          end
        end else begin
          w_gap_cnt_nxt = GAP_W'(r_gap_cnt + GAP_W'(1));
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_coin_req    <= 1'b0;
      r_coin_sel    <= 2'b00;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_change_left <= '0;
      r_coin_count  <= '0;
      r_underpaid   <= 1'b0;
      r_gap_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_coin_req    <= w_coin_req_nxt;
      r_coin_sel    <= w_coin_sel_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
      r_change_left <= w_change_left_nxt;
      r_coin_count  <= w_coin_count_nxt;
      r_underpaid   <= w_underpaid_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
    end
  end

  assign coin_req    = r_coin_req;
  assign coin_sel    = r_coin_sel;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign change_left = r_change_left;
  assign coin_count  = r_coin_count;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random sales checked against a greedy change model.
module tb_change_dispenser;

  localparam int unsigned GAP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] price;
  logic [10:0] paid;
  logic        coin_ack;
  logic        coin_req;
  logic [1:0]  coin_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] change_left;
  logic [6:0]  coin_count;

  int errors = 0;
  int checks = 0;

  change_dispenser #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .price(price), .paid(paid),
    .coin_ack(coin_ack), .coin_req(coin_req), .coin_sel(coin_sel), .busy(busy),
    .done(done), .err(err), .change_left(change_left), .coin_count(coin_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int coin_value(input int sel);
    case (sel)
      0: return 5;
      1: return 10;
      2: return 25;
      default: return 100;
    endcase
  endfunction

  // Reference: greedy change as a list of coin codes.
  function automatic void make_change(input int amt, output int q[$]);
    int a;
    q = {};
    a = amt;
    while (a > 0) begin
`ifdef DOLLAR_COIN_EN
      if (a >= 100) begin q.push_back(3); a -= 100; continue; end
`endif
      if (a >= 25) begin q.push_back(2); a -= 25; end
      else if (a >= 10) begin q.push_back(1); a -= 10; end
      else begin q.push_back(0); a -= 5; end
    end
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_req"}, int'(coin_req), 0);
    chk({tag, "_sel"}, int'(coin_sel), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_left"}, int'(change_left), 0);
    chk({tag, "_count"}, int'(coin_count), 0);
  endtask

  // first_dly < 0: random ack delay; rst_coin >= 0: reset while waiting for that coin's ack.
  task automatic run_txn(input int pr, input int pd, input int first_dly, input bit hold_ack,
                         input bit repulse, input int rst_coin);
    int exp_q[$];
    int left;
    int d;
    int n;
    bit bad;
    bad  = (pd < pr) || (((pd - pr) % 5) != 0);
    left = (pd >= pr) ? pd - pr : 0;
    if (!bad) make_change(left, exp_q);
    else exp_q = {};

    price = 11'(pr);
    paid  = 11'(pd);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("left_latched", int'(change_left), left);
    chk("count_cleared", int'(coin_count), 0);

    tick();
    if (bad) begin
      chk("err_pulse", int'(err), 1);
      chk("err_busy", int'(busy), 0);
      chk("err_left", int'(change_left), 0);
      tick();
      chk("err_one_cycle", int'(err), 0);
      chk("err_no_req", int'(coin_req), 0);
      chk("err_idle", int'(busy), 0);
      return;
    end
    chk("no_err", int'(err), 0);
    chk("no_early_req", int'(coin_req), 0);

    if (left == 0) begin
      tick();
      chk("zero_done", int'(done), 1);
      chk("zero_req", int'(coin_req), 0);
      chk("zero_count", int'(coin_count), 0);
      chk("zero_busy", int'(busy), 0);
      tick();
      chk("zero_done_pulse", int'(done), 0);
      return;
    end

    tick();
    chk("first_req_n2", int'(coin_req), 1);
    foreach (exp_q[k]) begin
      chk("coin_sel", int'(coin_sel), exp_q[k]);
      if (k == rst_coin) begin
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_zero("mid_rst");
        for (int j = 0; j < int'(GAP) + 4; j++) begin
          tick();
          chk("post_rst_done", int'(done), 0);
          chk("post_rst_req", int'(coin_req), 0);
        end
        return;
      end
      if (hold_ack) d = 0;
      else if (k == 0 && first_dly >= 0) d = first_dly;
      else d = int'($urandom_range(0, 3));
      coin_ack = hold_ack;
      for (int j = 0; j < d; j++) begin
        if (repulse && j == 2) start = 1'b1;
        tick();
        start = 1'b0;
        chk("req_held", int'(coin_req), 1);
        chk("sel_stable", int'(coin_sel), exp_q[k]);
      end
      coin_ack = 1'b1;
      tick();
      if (!hold_ack) coin_ack = 1'b0;
      left -= coin_value(exp_q[k]);
      chk("req_drop", int'(coin_req), 0);
      chk("left_after_coin", int'(change_left), left);
      chk("count_after_coin", int'(coin_count), k + 1);
      n = 0;
      while (!coin_req && !done && n < 400) begin
        tick();
        n++;
      end
      if (k < exp_q.size() - 1) begin
        chk("next_req", int'(coin_req), 1);
        chk("gap_len", n, int'(GAP));
      end else begin
        chk("done_pulse", int'(done), 1);
        chk("done_latency", n, int'(GAP) + 1);
        chk("done_busy", int'(busy), 0);
        chk("done_left", int'(change_left), 0);
        chk("done_count", int'(coin_count), exp_q.size());
      end
    end
    coin_ack = 1'b0;
    tick();
    chk("done_one_cycle", int'(done), 0);
    chk("count_hold", int'(coin_count), exp_q.size());
    chk("idle_no_req", int'(coin_req), 0);
  endtask

  initial begin
    int pr;
    int pd;
    rst = 1'b1;
    start = 1'b0;
    price = '0;
    paid = '0;
    coin_ack = 1'b0;
    tick();
    tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();

    run_txn(195, 300, 1, 1'b0, 1'b0, -1);
    run_txn(120, 100, -1, 1'b0, 1'b0, -1);
    run_txn(240, 240, -1, 1'b0, 1'b0, -1);
    run_txn(55, 100, 10, 1'b0, 1'b1, -1);
    run_txn(55, 100, 0, 1'b0, 1'b0, 1);
    run_txn(0, 1515, -1, 1'b1, 1'b0, -1);
    run_txn(0, 0, -1, 1'b0, 1'b0, -1);
    run_txn(100, 103, -1, 1'b0, 1'b0, -1);
    run_txn(1515, 0, -1, 1'b0, 1'b0, -1);
    run_txn(5, 10, -1, 1'b1, 1'b0, -1);

    for (int t = 0; t < 15; t++) begin
      pr = int'($urandom_range(0, 1515));
      if ($urandom_range(0, 3) != 0) pd = pr + 5 * int'($urandom_range(0, (1515 - pr) / 5));
      else pd = int'($urandom_range(0, 1515));
      run_txn(pr, pd, -1, 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter: GAP_CYCLES, default 2, idle cycles with coin_req low between consecutive coins (legal 1..255).
REQ-002 clk  in  1  single system clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle request to dispense change for the current sale.
REQ-005 price  in  11  item price in cents (0..1515).
REQ-006 paid  in  11  amount inserted in cents (0..1515).
REQ-007 coin_ack  in  1  hopper has ejected the requested coin; sampled only while coin_req=1.
REQ-008 coin_req  out  1  request to eject one coin of type coin_sel.
REQ-009 coin_sel  out  2  coin type: 00 nickel (5), 01 dime (10), 10 quarter (25), 11 dollar (100).
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle pulse when change is fully dispensed.
REQ-012 err  out  1  one-cycle pulse when the request is rejected.
REQ-013 change_left  out  11  cents still owed.
REQ-014 coin_count  out  7  coins ejected for the current request.

Function
REQ-015 The FSM SHALL have states IDLE, CHECK, REQ, GAP, DONE.
REQ-016 IDLE: start=1 at edge N latches change_left=paid-price (11-bit, computed only if paid>=price, else 0), clears coin_count, stores a paid<price flag, and enters CHECK.
REQ-017 start SHALL be ignored in every state other than IDLE.
REQ-018 CHECK (edge N+1): paid<price, or change_left not a multiple of 5, asserts err for one cycle, clears change_left, and returns to IDLE. change_left=0 goes to DONE. Otherwise the FSM goes to REQ.
REQ-019 REQ: coin_req=1 with coin_sel set to the largest enabled coin value <=change_left. The first coin_req SHALL appear at edge N+2.
REQ-020 coin_sel SHALL stay stable while coin_req=1. coin_req SHALL stay high until coin_ack is sampled high.
REQ-021 On the edge at which coin_ack=1 in REQ, the block SHALL subtract the coin value from change_left, increment coin_count, drop coin_req, and enter GAP.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles. It then goes to DONE if change_left=0, else to REQ.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE. change_left=0 and coin_count hold their values until the next start.
REQ-024 coin_ack outside REQ SHALL have no effect. coin_ack held high continuously SHALL yield at most one coin per REQ visit.
REQ-025 change_left SHALL never underflow. coin_count SHALL never exceed 62 for in-range inputs.

Reset
REQ-026 rst=1 at any edge SHALL force IDLE, coin_req=0, coin_sel=00, busy=0, done=0, err=0, change_left=0, coin_count=0, including mid-dispense. rst takes priority over start and coin_ack.

Configuration
REQ-027 Macro DOLLAR_COIN_EN. Defined: dollar coins (coin_sel=11) are used in greedy selection. Undefined: only 25/10/5 are used and coin_sel=11 is never driven.

Verification
REQ-028 price=195, paid=300, DOLLAR_COIN_EN defined, ack 1 cycle after each req -> coins 11 then 00, coin_count=2, done pulse, change_left=0.
REQ-029 Same stimulus with DOLLAR_COIN_EN undefined -> coins 10,10,10,10,00, coin_count=5, done pulse.
REQ-030 price=120, paid=100, start -> err pulse at edge N+1, coin_req never asserted, busy low from N+2.
REQ-031 price=240, paid=240 -> no coin_req, done pulse at N+2, coin_count=0.
REQ-032 price=55, paid=100, ack withheld 10 cycles on first coin, start re-pulsed meanwhile -> coin_req/coin_sel=10 held stable, extra start ignored, coins 10,01,01 delivered.
REQ-033 rst asserted while waiting for ack on second coin -> next edge: coin_req=0, busy=0, change_left=0, coin_count=0, no done pulse.
